dcache_nway: RTL and testbench

DCACHE_NWAY -- requirements
Module: dcache_nway

---
 rtl/dcache_nway.sv | 188 ++++++++++++++++++
 tb/tb_dcache_nway.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_nway.sv
// N-way set-associative write-back data cache with LRU replacement and a flush engine.
// Each access sees one 32-bit word of a LINE_BITS line; misses go to memory one whole line at a time.
module dcache_nway #(
  parameter int NUM_SETS  = 16,
  parameter int NUM_WAYS  = 2,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_MemRead_i,
  input  logic                 cpu_MemWrite_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  input  logic                 flush_req_i,
  output logic                 flush_done_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [31:0]          mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o,
  output logic [2:0]           state_o
);
  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 27 - IDX_W;
  localparam int WAY_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int AGE_W = WAY_W;

  typedef enum logic [2:0] {
    S_IDLE, S_WRITEBACK, S_REFILL, S_FLUSH_SCAN, S_FLUSH_WB
  } state_t;

  state_t state_q, state_d;

  logic                 valid_q [NUM_SETS][NUM_WAYS];
  logic                 dirty_q [NUM_SETS][NUM_WAYS];
  logic [TAG_W-1:0]     tag_q   [NUM_SETS][NUM_WAYS];
  logic [LINE_BITS-1:0] data_q  [NUM_SETS][NUM_WAYS];
  logic [AGE_W-1:0]     age_q   [NUM_SETS][NUM_WAYS];

  logic [WAY_W-1:0] victim_q, victim_c, hit_way, lru_way;
  logic [IDX_W-1:0] scan_set_q;
  logic [WAY_W-1:0] scan_way_q;
  logic             flush_pend_q, flush_done_q, start_flush;
  logic             req, hit_any, hit, fill, lru_en, scan_dirty, scan_last;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic [2:0]       word;
  logic [LINE_BITS-1:0] hit_line;
  logic             unused_addr_bits;

  assign idx  = cpu_addr_i[5 +: IDX_W];
  assign tag  = cpu_addr_i[31 -: TAG_W];
  assign word = cpu_addr_i[4:2];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign req          = cpu_MemRead_i | cpu_MemWrite_i;
  assign hit          = (state_q == S_IDLE) && req && hit_any;
  assign cpu_stall_o  = req && !hit;
  assign hit_line     = data_q[idx][hit_way];
  assign cpu_data_o   = hit ? hit_line[{word, 5'b0} +: 32] : 32'd0;
  assign fill         = (state_q == S_REFILL) && mem_ack_i;
  assign lru_en       = hit || fill;
  assign lru_way      = hit ? hit_way : victim_q;
  assign scan_dirty   = valid_q[scan_set_q][scan_way_q] && dirty_q[scan_set_q][scan_way_q];
  assign scan_last    = (scan_set_q == IDX_W'(NUM_SETS - 1)) && (scan_way_q == WAY_W'(NUM_WAYS - 1));
  assign flush_done_o = flush_done_q;
  assign state_o      = state_q;

  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Oldest way first, then overridden by the lowest-numbered invalid way if any.
  always_comb begin
    victim_c = '0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (age_q[idx][w] == AGE_W'(NUM_WAYS - 1)) victim_c = WAY_W'(w);
    for (int w = NUM_WAYS - 1; w >= 0; w--)
      if (!valid_q[idx][w]) victim_c = WAY_W'(w);
  end

  // Memory handshake: mem_enable_o requests a transfer and holds addr/data/write stable;
  // the transfer completes on the rising edge where mem_ack_i (a one-cycle pulse) is high.
  always_comb begin
    state_d      = state_q;
    start_flush  = 1'b0;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = 32'd0;
    mem_data_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (req && !hit_any)
          state_d = (valid_q[idx][victim_c] && dirty_q[idx][victim_c]) ? S_WRITEBACK : S_REFILL;
        else if (!req && (flush_req_i || flush_pend_q)) begin
          state_d     = S_FLUSH_SCAN;
          start_flush = 1'b1;
        end
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[idx][victim_q], idx, 5'b0};
        mem_data_o   = data_q[idx][victim_q];
        if (mem_ack_i) state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {tag, idx, 5'b0};
        if (mem_ack_i) state_d = S_IDLE;
      end
      S_FLUSH_SCAN: begin
        if (scan_dirty) state_d = S_FLUSH_WB;
        else if (scan_last) state_d = S_IDLE;
      end
      S_FLUSH_WB: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[scan_set_q][scan_way_q], scan_set_q, 5'b0};
        mem_data_o   = data_q[scan_set_q][scan_way_q];
        if (mem_ack_i) state_d = scan_last ? S_IDLE : S_FLUSH_SCAN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q      <= S_IDLE;
      victim_q     <= '0;
      scan_set_q   <= '0;
      scan_way_q   <= '0;
      flush_pend_q <= 1'b0;
      flush_done_q <= 1'b0;
      for (int s = 0; s < NUM_SETS; s++)
        for (int w = 0; w < NUM_WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          dirty_q[s][w] <= 1'b0;
          age_q[s][w]   <= AGE_W'(w);
        end
    end else begin
      state_q      <= state_d;
      flush_pend_q <= (flush_pend_q | flush_req_i) & ~start_flush;
      flush_done_q <= 1'b0;
      if ((state_q == S_IDLE) && req && !hit_any) victim_q <= victim_c;
      if (hit && cpu_MemWrite_i) begin
        data_q[idx][hit_way][{word, 5'b0} +: 32] <= cpu_data_i;
        dirty_q[idx][hit_way] <= 1'b1;
      end
      if (fill) begin
        data_q[idx][victim_q]  <= mem_data_i;
        tag_q[idx][victim_q]   <= tag;
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      // Accessed way becomes youngest; only ways younger than it age by one.
      if (lru_en && (NUM_WAYS > 1)) begin
        for (int w = 0; w < NUM_WAYS; w++) begin
          if (w == int'(lru_way)) age_q[idx][w] <= '0;
          else if (age_q[idx][w] < age_q[idx][lru_way]) age_q[idx][w] <= age_q[idx][w] + 1'b1;
        end
      end
      if (((state_q == S_FLUSH_SCAN) && !scan_dirty) || ((state_q == S_FLUSH_WB) && mem_ack_i)) begin
        if (state_q == S_FLUSH_WB) dirty_q[scan_set_q][scan_way_q] <= 1'b0;
        if (scan_last) begin
          flush_done_q <= 1'b1;
          scan_set_q   <= '0;
          scan_way_q   <= '0;
        end else if (scan_way_q == WAY_W'(NUM_WAYS - 1)) begin
          scan_way_q <= '0;
          scan_set_q <= scan_set_q + 1'b1;
        end else begin
          scan_way_q <= scan_way_q + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_dcache_nway.sv
// Directed bench for dcache_nway: a default 2-way instance and a 4-way instance,
// each backed by a fixed-latency line memory that logs every completed transfer.
module tb_dcache_nway;
  logic clk, rst;
  int checks = 0;
  int errors = 0;

  logic        rd_a, wr_a, freq_a, fdone_a, ack_a, en_a, we_a, stall_a;
  logic [31:0] addr_a, wdat_a, dout_a, maddr_a;
  logic [255:0] mdi_a, mdo_a;
  logic [2:0]  st_a;
  logic        rd_b, wr_b, freq_b, fdone_b, ack_b, en_b, we_b, stall_b;
  logic [31:0] addr_b, wdat_b, dout_b, maddr_b;
  logic [255:0] mdi_b, mdo_b;
  logic [2:0]  st_b;

  logic [255:0] mem_a [128];
  logic [255:0] mem_b [128];
  logic         init_a = 1'b0, init_b = 1'b0;
  int           cnt_a, cnt_b;
  int           done_cnt_a = 0;
  logic [31:0]  wb_word1_a;
  logic [32:0]  act_a_q[$];
  logic [32:0]  act_b_q[$];
  logic [32:0]  exp_q[$];

  dcache_nway dut_a (
    .clk_i(clk), .rst_i(rst), .cpu_MemRead_i(rd_a), .cpu_MemWrite_i(wr_a),
    .cpu_addr_i(addr_a), .cpu_data_i(wdat_a), .cpu_data_o(dout_a), .cpu_stall_o(stall_a),
    .flush_req_i(freq_a), .flush_done_o(fdone_a), .mem_data_i(mdi_a), .mem_ack_i(ack_a),
    .mem_data_o(mdo_a), .mem_addr_o(maddr_a), .mem_enable_o(en_a), .mem_write_o(we_a),
    .state_o(st_a));

  dcache_nway #(.NUM_SETS(16), .NUM_WAYS(4), .LINE_BITS(256)) dut_b (
    .clk_i(clk), .rst_i(rst), .cpu_MemRead_i(rd_b), .cpu_MemWrite_i(wr_b),
    .cpu_addr_i(addr_b), .cpu_data_i(wdat_b), .cpu_data_o(dout_b), .cpu_stall_o(stall_b),
    .flush_req_i(freq_b), .flush_done_o(fdone_b), .mem_data_i(mdi_b), .mem_ack_i(ack_b),
    .mem_data_o(mdo_b), .mem_addr_o(maddr_b), .mem_enable_o(en_b), .mem_write_o(we_b),
    .state_o(st_b));

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] init_line(input int i);
    logic [255:0] l;
    if (i == 0) l = 256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;
    else for (int k = 0; k < 8; k++) l[k*32 +: 32] = 32'hA000_0000 | 32'(i << 8) | 32'(k);
    return l;
  endfunction

  // Memory models: ack three edges after a request is first seen.
  always @(posedge clk) begin
    if (!init_a) begin
      for (int i = 0; i < 128; i++) mem_a[i] <= init_line(i);
      init_a <= 1'b1;
    end
    if (!rst) begin
      cnt_a <= 0; ack_a <= 1'b0;
    end else begin
      ack_a <= 1'b0;
      if (en_a && !ack_a) begin
        if (cnt_a == 2) begin
          ack_a <= 1'b1; cnt_a <= 0;
          act_a_q.push_back({we_a, maddr_a});
          if (we_a) begin mem_a[maddr_a[11:5]] <= mdo_a; wb_word1_a <= mdo_a[63:32]; end
          else mdi_a <= mem_a[maddr_a[11:5]];
        end else cnt_a <= cnt_a + 1;
      end else cnt_a <= 0;
    end
    if (fdone_a) done_cnt_a <= done_cnt_a + 1;
  end

  always @(posedge clk) begin
    if (!init_b) begin
      for (int i = 0; i < 128; i++) mem_b[i] <= init_line(i);
      init_b <= 1'b1;
    end
    if (!rst) begin
      cnt_b <= 0; ack_b <= 1'b0;
    end else begin
      ack_b <= 1'b0;
      if (en_b && !ack_b) begin
        if (cnt_b == 2) begin
          ack_b <= 1'b1; cnt_b <= 0;
          act_b_q.push_back({we_b, maddr_b});
          if (we_b) mem_b[maddr_b[11:5]] <= mdo_b;
          else mdi_b <= mem_b[maddr_b[11:5]];
        end else cnt_b <= cnt_b + 1;
      end else cnt_b <= 0;
    end
  end

  // Driver: mode 0 = load, 1 = store, 2 = load+store together.
  task automatic cpu_access(input bit which, input int mode, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output int stall_cyc);
    @(negedge clk);
    if (!which) begin rd_a = (mode != 1); wr_a = (mode != 0); addr_a = addr; wdat_a = wdata; end
    else begin rd_b = (mode != 1); wr_b = (mode != 0); addr_b = addr; wdat_b = wdata; end
    #1;
    stall_cyc = 0;
    while ((which ? stall_b : stall_a) && stall_cyc < 300) begin
      @(negedge clk); #1; stall_cyc++;
    end
    checks++;
    if (which ? stall_b : stall_a) begin
      errors++;
      $display("FAIL access_timeout addr=%h still stalled after %0d cycles", addr, stall_cyc);
    end
    rdata = which ? dout_b : dout_a;
    @(posedge clk); #1;
    if (!which) begin rd_a = 1'b0; wr_a = 1'b0; end else begin rd_b = 1'b0; wr_b = 1'b0; end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (stall_a !== 1'b0) begin errors++; $display("FAIL reset_stall got %b want 0", stall_a); end
    if (en_a !== 1'b0) begin errors++; $display("FAIL reset_mem_enable got %b want 0", en_a); end
    if (we_a !== 1'b0) begin errors++; $display("FAIL reset_mem_write got %b want 0", we_a); end
    if (fdone_a !== 1'b0) begin errors++; $display("FAIL reset_flush_done got %b want 0", fdone_a); end
    if (maddr_a !== 32'd0) begin errors++; $display("FAIL reset_mem_addr got %h want 0", maddr_a); end
    if (st_a !== 3'd0) begin errors++; $display("FAIL reset_state got %0d want 0", st_a); end
    rst = 1'b1;
  endtask

  task automatic test_cold_read_miss();
    logic [31:0] d; int sc; int base;
    base = act_a_q.size();
    cpu_access(0, 0, 32'h0000, 32'd0, d, sc);
    checks += 4;
    if (d !== 32'hEEEEFFFF) begin errors++; $display("FAIL cold_miss_data got %h want eeeeffff", d); end
    if (sc !== 5) begin errors++; $display("FAIL cold_miss_latency got %0d want 5", sc); end
    if (act_a_q.size() - base !== 1) begin errors++; $display("FAIL cold_miss_txn_count got %0d want 1", act_a_q.size() - base); end
    else if (act_a_q[base] !== {1'b0, 32'h0}) begin errors++; $display("FAIL cold_miss_txn got %h want 0", act_a_q[base]); end
    cpu_access(0, 0, 32'h0000, 32'd0, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL reread_hit_stall got %0d want 0", sc); end
  endtask

  task automatic test_write_hit();
    logic [31:0] d; int sc; int base;
    base = act_a_q.size();
    cpu_access(0, 1, 32'h0004, 32'h12345678, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL write_hit_stall got %0d want 0", sc); end
    cpu_access(0, 0, 32'h0004, 32'd0, d, sc);
    checks += 3;
    if (sc !== 0) begin errors++; $display("FAIL read_after_write_stall got %0d want 0", sc); end
    if (d !== 32'h12345678) begin errors++; $display("FAIL read_after_write got %h want 12345678", d); end
    if (act_a_q.size() !== base) begin errors++; $display("FAIL write_hit_mem_traffic got %0d want 0", act_a_q.size() - base); end
  endtask

  task automatic test_conflict_eviction();
    logic [31:0] d; int sc; int base;
    base = act_a_q.size();
    cpu_access(0, 0, 32'h0200, 32'd0, d, sc);
    cpu_access(0, 0, 32'h0400, 32'd0, d, sc);
    checks += 4;
    if (d !== 32'hA0002000) begin errors++; $display("FAIL evict_refill_data got %h want a0002000", d); end
    if (sc !== 9) begin errors++; $display("FAIL evict_latency got %0d want 9", sc); end
    if (wb_word1_a !== 32'h12345678) begin errors++; $display("FAIL evict_wb_word1 got %h want 12345678", wb_word1_a); end
    if (mem_a[0][63:32] !== 32'h12345678) begin errors++; $display("FAIL evict_mem_word1 got %h want 12345678", mem_a[0][63:32]); end
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h0200});
    exp_q.push_back({1'b1, 32'h0000});
    exp_q.push_back({1'b0, 32'h0400});
    checks++;
    if (act_a_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL evict_txn_count got %0d want 3", act_a_q.size() - base);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_a_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL evict_txn%0d got %h want %h", i, act_a_q[base+i], exp_q[i]); end
      end
    end
    cpu_access(0, 0, 32'h0200, 32'd0, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL evict_survivor_hit got %0d want 0", sc); end
  endtask

  task automatic test_flush();
    logic [31:0] d; int sc; int base; int base_done; int cyc;
    cpu_access(0, 1, 32'h0200, 32'hCAFE0001, d, sc);
    cpu_access(0, 1, 32'h0060, 32'hBEEF0003, d, sc);
    base = act_a_q.size();
    base_done = done_cnt_a;
    @(negedge clk); freq_a = 1'b1;
    @(negedge clk); freq_a = 1'b0;
    cyc = 0;
    while (done_cnt_a == base_done && cyc < 500) begin @(negedge clk); cyc++; end
    repeat (5) @(negedge clk);
    checks += 3;
    if (done_cnt_a - base_done !== 1) begin errors++; $display("FAIL flush_done_pulses got %0d want 1", done_cnt_a - base_done); end
    if (mem_a[16][31:0] !== 32'hCAFE0001) begin errors++; $display("FAIL flush_mem_0200 got %h want cafe0001", mem_a[16][31:0]); end
    if (mem_a[3][31:0] !== 32'hBEEF0003) begin errors++; $display("FAIL flush_mem_0060 got %h want beef0003", mem_a[3][31:0]); end
    exp_q.delete();
    exp_q.push_back({1'b1, 32'h0200});
    exp_q.push_back({1'b1, 32'h0060});
    checks++;
    if (act_a_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL flush_txn_count got %0d want 2", act_a_q.size() - base);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_a_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL flush_txn%0d got %h want %h", i, act_a_q[base+i], exp_q[i]); end
      end
    end
    cpu_access(0, 0, 32'h0200, 32'd0, d, sc);
    checks += 2;
    if (sc !== 0) begin errors++; $display("FAIL flush_hit_0200 stall got %0d want 0", sc); end
    if (d !== 32'hCAFE0001) begin errors++; $display("FAIL flush_data_0200 got %h want cafe0001", d); end
    cpu_access(0, 0, 32'h0060, 32'd0, d, sc);
    checks += 2;
    if (sc !== 0) begin errors++; $display("FAIL flush_hit_0060 stall got %0d want 0", sc); end
    if (d !== 32'hBEEF0003) begin errors++; $display("FAIL flush_data_0060 got %h want beef0003", d); end
  endtask

  task automatic test_reset_mid_refill();
    logic [31:0] d; int sc; int base;
    @(negedge clk); rd_a = 1'b1; addr_a = 32'h0800;
    @(negedge clk); #1;
    checks += 3;
    if (en_a !== 1'b1) begin errors++; $display("FAIL refill_enable got %b want 1", en_a); end
    if (we_a !== 1'b0) begin errors++; $display("FAIL refill_write got %b want 0", we_a); end
    if (maddr_a !== 32'h0800) begin errors++; $display("FAIL refill_addr got %h want 00000800", maddr_a); end
    rst = 1'b0; rd_a = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (en_a !== 1'b0) begin errors++; $display("FAIL reset_abort_enable got %b want 0", en_a); end
    rst = 1'b1;
    base = act_a_q.size();
    cpu_access(0, 0, 32'h0800, 32'd0, d, sc);
    checks += 3;
    if (sc == 0) begin errors++; $display("FAIL post_reset_miss stall got %0d want >0", sc); end
    if (d !== 32'hA0004000) begin errors++; $display("FAIL post_reset_data got %h want a0004000", d); end
    if (act_a_q.size() - base !== 1) begin errors++; $display("FAIL post_reset_txn_count got %0d want 1", act_a_q.size() - base); end
  endtask

  task automatic test_read_write_both();
    logic [31:0] d; int sc;
    cpu_access(0, 2, 32'h0804, 32'h5A5A5A5A, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL rw_both_stall got %0d want 0", sc); end
    cpu_access(0, 0, 32'h0804, 32'd0, d, sc);
    checks++;
    if (d !== 32'h5A5A5A5A) begin errors++; $display("FAIL rw_both_data got %h want 5a5a5a5a", d); end
    cpu_access(0, 0, 32'h0800, 32'd0, d, sc);
    checks++;
    if (d !== 32'hA0004000) begin errors++; $display("FAIL rw_both_neighbor got %h want a0004000", d); end
  endtask

  task automatic test_lru_4way();
    logic [31:0] d; int sc; int base;
    logic [31:0] tags [5];
    tags[0] = 32'h0000; tags[1] = 32'h0200; tags[2] = 32'h0400; tags[3] = 32'h0600; tags[4] = 32'h0000;
    for (int i = 0; i < 5; i++) cpu_access(1, 0, tags[i], 32'd0, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL lru_retouch_a stall got %0d want 0", sc); end
    base = act_b_q.size();
    cpu_access(1, 0, 32'h0800, 32'd0, d, sc);
    checks++;
    if (d !== 32'hA0004000) begin errors++; $display("FAIL lru_e_data got %h want a0004000", d); end
    cpu_access(1, 0, 32'h0000, 32'd0, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL lru_a_kept stall got %0d want 0", sc); end
    cpu_access(1, 0, 32'h0400, 32'd0, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL lru_c_kept stall got %0d want 0", sc); end
    cpu_access(1, 0, 32'h0600, 32'd0, d, sc);
    checks++;
    if (sc !== 0) begin errors++; $display("FAIL lru_d_kept stall got %0d want 0", sc); end
    cpu_access(1, 0, 32'h0200, 32'd0, d, sc);
    checks++;
    if (sc == 0) begin errors++; $display("FAIL lru_b_evicted stall got %0d want >0", sc); end
    exp_q.delete();
    exp_q.push_back({1'b0, 32'h0800});
    exp_q.push_back({1'b0, 32'h0200});
    checks++;
    if (act_b_q.size() - base !== exp_q.size()) begin
      errors++; $display("FAIL lru_txn_count got %0d want 2", act_b_q.size() - base);
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (act_b_q[base+i] !== exp_q[i]) begin errors++; $display("FAIL lru_txn%0d got %h want %h", i, act_b_q[base+i], exp_q[i]); end
      end
    end
  endtask

  initial begin
    rd_a = 0; wr_a = 0; addr_a = 0; wdat_a = 0; freq_a = 0;
    rd_b = 0; wr_b = 0; addr_b = 0; wdat_b = 0; freq_b = 0;
    test_reset();
    test_cold_read_miss();
    test_write_hit();
    test_conflict_eviction();
    test_flush();
    test_reset_mid_refill();
    test_read_write_both();
    test_lru_4way();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end
endmodule
